p_beid_peripheral_id_reg_bank: RTL and testbench
================================================

// Module: p_beid_peripheral_id_reg_bank
// PURPOSE
//  Parametrised successor to the single static tie-off register: a bank of NUM_REGS
//  ID/revision registers, each WIDTH bits. Each register captures its tie-off once
//  after reset and stays visible as a flop for ECO edits. Until lock, software may
//  override any register; after lock the bank is read-only. Sits in the peripheral
//  ID space and feeds the bus read mux through a registered read port.
// PARAMETERS
//  NUM_REGS  4  number of ID registers (1..16)
//  WIDTH     8  bits per register (1..32)
//  ADDR_W    2  register index width; must satisfy 2**ADDR_W >= NUM_REGS
// PORTS
//  clk        in   1                 single clock; all flops rise-edge
//  reset_n    in   1                 synchronous, active-low reset
//  static_i   in   NUM_REGS*WIDTH    tie-off values; reg k = static_i[k*WIDTH +: WIDTH]
//  wr_en      in   1                 override write strobe
//  wr_addr    in   ADDR_W            override register index
//  wr_data    in   WIDTH             override data
//  lock_i     in   1                 lock request pulse
//  rd_en      in   1                 read strobe
//  rd_addr    in   ADDR_W            read register index
//  rd_data    out  WIDTH             read data, valid when rd_valid=1
//  rd_valid   out  1                 one-cycle pulse, one cycle after rd_en
//  static_o   out  NUM_REGS*WIDTH    current register contents, same packing as static_i
//  locked_o   out  1                 1 once the bank is locked
//  err_o      out  1                 one-cycle pulse on a rejected access
// BEHAVIOUR
//  - Reset: sync, active-low, sampled on clk. While reset_n=0 every output is 0 and
//    all registers are 0. The FSM state is CAPTURE.
//  - FSM: CAPTURE -> RUN -> LOCKED. No other transitions. reset_n=0 in any state
//    forces CAPTURE and clears registers and locked_o on that edge.
//  - CAPTURE: lasts exactly one cycle, the first edge with reset_n=1.
//    All registers load static_i. State then goes to RUN.
//    A wr_en in this cycle is rejected: no write happens and err_o pulses.
//    A rd_en in this cycle is served and returns the pre-capture value (0).
//    lock_i is ignored.
//  - RUN, write: wr_en with wr_addr<NUM_REGS writes wr_data to that register on the
//    same edge. wr_addr>=NUM_REGS is rejected: no write, err_o=1 next cycle.
//  - RUN, lock: lock_i=1 moves the state to LOCKED and sets locked_o=1 on the next
//    edge. A write in the same cycle as lock_i is still accepted (write before lock).
//  - LOCKED: every wr_en is rejected with an err_o pulse. Contents hold until reset.
//    lock_i has no further effect.
//  - Read (all states): rd_en at edge N gives rd_valid=1 and rd_data at edge N+1.
//    Latency is exactly 1 cycle and back-to-back reads give one result per cycle.
//    rd_data holds its last value when rd_valid=0.
//    rd_addr>=NUM_REGS returns rd_data=0, rd_valid=1, err_o=1.
//  - Read and write to the same index in one cycle: the read returns the OLD value.
//  - err_o is an OR of write rejects and read range errors. It is a 1-cycle pulse
//    per offending cycle and is not sticky.
//  - static_o is taken directly from the register flops (no extra latency) and
//    changes on the edge that captures or writes.
//  - Once CAPTURE is done, static_i changes have no effect until the next reset.
// TESTING
//  1 reset_n low 3 cycles, static_i={8'h44,8'h33,8'h22,8'h11} -> outputs 0 in reset;
//    1 cycle after release static_o=32'h44332211 and locked_o=0
//  2 RUN: wr_en addr=2 data=8'hA5, then rd_en addr=2 -> rd_valid next cycle with
//    rd_data=8'hA5; static_o[23:16]=8'hA5
//  3 same cycle wr addr=1 data=8'h7E and rd addr=1 -> rd_data=8'h22 (old value);
//    next read of addr=1 -> 8'h7E
//  4 lock_i with wr addr=0 data=8'hF0 -> write lands and locked_o=1; next wr addr=0
//    data=8'h0F -> err_o pulse, reg0 stays 8'hF0
//  5 NUM_REGS=3, ADDR_W=2: rd addr=3 -> rd_data=0, rd_valid=1, err_o=1;
//    wr addr=3 -> err_o=1, no register changes
//  6 reset_n low mid-run while LOCKED -> locked_o=0 and regs 0 next edge; after release
//    recapture current static_i and override writes accepted again

Source files
------------

// File: rtl/p_beid_peripheral_id_reg_bank_if.sv
// Access port of the peripheral ID register bank: override writes, registered reads and error pulse.
// The master drives the strobes. The slave returns read data, read valid and the error pulse; there is no backpressure.
interface p_beid_peripheral_id_reg_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              err_o;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, err_o
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, err_o
    );
endinterface

// File: rtl/p_beid_peripheral_id_reg_bank.sv
// Bank of ID/revision flops: captures tie-offs once after reset, allows overrides until lock. Reads have 1-cycle latency.
// Writes commit on the strobe edge. There is no backpressure: every strobe is served or rejected with a one-cycle err_o pulse.
module p_beid_peripheral_id_reg_bank #(
    parameter int NUM_REGS = 4,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REGS*WIDTH-1:0] static_i,
    input  logic                      lock_i,
    p_beid_peripheral_id_reg_bank_if.slave bus,
    output logic [NUM_REGS*WIDTH-1:0] static_o,
    output logic                      locked_o
);

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_RUN     = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             capture;
    logic             wr_allowed;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_hit;
    logic             wr_rej;
    logic             rd_rej;
    logic [WIDTH-1:0] rd_mux;
    logic [WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CAPTURE: state_nxt = ST_RUN;
            ST_RUN:     state_nxt = lock_i ? ST_LOCKED : ST_RUN;
            ST_LOCKED:  state_nxt = ST_LOCKED;
            default:    state_nxt = ST_CAPTURE;
        endcase
    end

    always_comb begin
        capture    = 1'b0;
        wr_allowed = 1'b0;
        locked_o   = 1'b0;
        case (state)
            ST_CAPTURE: capture    = 1'b1;
            ST_RUN:     wr_allowed = 1'b1;
            ST_LOCKED:  locked_o   = 1'b1;
            default:    capture    = 1'b0;
        endcase
    end

    // Index widths may exceed the bank size, so out-of-range indices are rejected rather than aliased.
    assign wr_in_range = int'(bus.wr_addr) < NUM_REGS;
    assign rd_in_range = int'(bus.rd_addr) < NUM_REGS;
    assign wr_hit      = bus.wr_en & wr_allowed & wr_in_range;
    assign wr_rej      = bus.wr_en & ~wr_hit;
    assign rd_rej      = bus.rd_en & ~rd_in_range;

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.rd_addr == ADDR_W'(k)) begin
                rd_mux = regs[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= static_i[k*WIDTH +: WIDTH];
            end
        end else if (wr_hit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (bus.wr_addr == ADDR_W'(k)) begin
                    regs[k] <= bus.wr_data;
                end
            end
        end
    end

    // rd_mux samples the pre-edge contents, so a same-cycle write to the read index returns the old value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.err_o    <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= rd_in_range ? rd_mux : '0;
            end
            bus.err_o <= wr_rej | rd_rej;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign static_o[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_p_beid_peripheral_id_reg_bank.sv
// Randomised and directed checks of the ID register bank against a behavioural bank model.
module tb_p_beid_peripheral_id_reg_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] static4;
    logic [23:0] static3;
    logic        lock4;
    logic        lock3;
    logic [31:0] static_o4;
    logic [23:0] static_o3;
    logic        locked4;
    logic        locked3;

    int errors = 0;
    int checks = 0;

    p_beid_peripheral_id_reg_bank_if #(.WIDTH(8), .ADDR_W(2)) bus4 ();
    p_beid_peripheral_id_reg_bank_if #(.WIDTH(8), .ADDR_W(2)) bus3 ();

    p_beid_peripheral_id_reg_bank #(.NUM_REGS(4), .WIDTH(8), .ADDR_W(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .static_i(static4), .lock_i(lock4),
        .bus(bus4.slave), .static_o(static_o4), .locked_o(locked4)
    );

    p_beid_peripheral_id_reg_bank #(.NUM_REGS(3), .WIDTH(8), .ADDR_W(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .static_i(static3), .lock_i(lock3),
        .bus(bus3.slave), .static_o(static_o3), .locked_o(locked3)
    );

    always #5 clk = ~clk;

    // Reference model for the 4-register bank: contents, lifecycle phase and expected read port.
    logic [7:0] m4 [4];
    int         phase4;       // 0 = awaiting capture, 1 = overridable, 2 = locked
    logic [7:0] e_rd_data;
    logic       e_rd_valid;
    logic       e_err;

    function automatic logic [31:0] pack4();
        return {m4[3], m4[2], m4[1], m4[0]};
    endfunction

    task automatic model4_step();
        logic rd_bad;
        logic wr_ok;
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) m4[k] = 8'h00;
            phase4     = 0;
            e_rd_valid = 1'b0;
            e_rd_data  = 8'h00;
            e_err      = 1'b0;
        end else begin
            rd_bad     = bus4.rd_en && (int'(bus4.rd_addr) >= 4);
            e_rd_valid = bus4.rd_en;
            if (bus4.rd_en) e_rd_data = rd_bad ? 8'h00 : m4[bus4.rd_addr];
            wr_ok = bus4.wr_en && (phase4 == 1) && (int'(bus4.wr_addr) < 4);
            e_err = (bus4.wr_en && !wr_ok) || rd_bad;
            if (phase4 == 0) begin
                for (int k = 0; k < 4; k++) m4[k] = static4[k*8 +: 8];
                phase4 = 1;
            end else if (phase4 == 1) begin
                if (wr_ok) m4[bus4.wr_addr] = bus4.wr_data;
                if (lock4) phase4 = 2;
            end
        end
    endtask

    task automatic tick();
        model4_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus4.wr_en = 0; bus4.wr_addr = 0; bus4.wr_data = 0;
        bus4.rd_en = 0; bus4.rd_addr = 0; lock4 = 0;
        bus3.wr_en = 0; bus3.wr_addr = 0; bus3.wr_data = 0;
        bus3.rd_en = 0; bus3.rd_addr = 0; lock3 = 0;
    endtask

    task automatic test_reset();
        idle_all();
        static4 = 32'h44332211;
        static3 = 24'hCCBBAA;
        reset_n = 1'b0;
        bus4.rd_en = 1; bus4.rd_addr = 2'd1;
        bus4.wr_en = 1; bus4.wr_addr = 2'd0; bus4.wr_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({static_o4, locked4, bus4.rd_valid, bus4.rd_data, bus4.err_o} !== 43'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got static=%h lock=%b vld=%b dat=%h err=%b exp all 0",
                         i, static_o4, locked4, bus4.rd_valid, bus4.rd_data, bus4.err_o);
            end
        end
        // Capture cycle: read returns pre-capture 0, write is rejected.
        reset_n = 1'b1;
        tick();
        checks++;
        if (static_o4 !== 32'h44332211 || locked4 !== 1'b0) begin
            errors++;
            $display("FAIL capture_static got %h lock=%b exp 44332211 lock=0", static_o4, locked4);
        end
        checks++;
        if (bus4.rd_valid !== 1'b1 || bus4.rd_data !== 8'h00 || bus4.err_o !== 1'b1) begin
            errors++;
            $display("FAIL capture_access got vld=%b dat=%h err=%b exp 1 00 1",
                     bus4.rd_valid, bus4.rd_data, bus4.err_o);
        end
        checks++;
        if (static_o3 !== 24'hCCBBAA) begin
            errors++;
            $display("FAIL capture_static3 got %h exp ccbbaa", static_o3);
        end
        idle_all();
        static4 = 32'hDEADBEEF;
        tick();
        checks++;
        if (static_o4 !== 32'h44332211 || bus4.err_o !== 1'b0 || bus4.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_capture_hold got static=%h err=%b vld=%b exp 44332211 0 0",
                     static_o4, bus4.err_o, bus4.rd_valid);
        end
    endtask

    task automatic test_write_read();
        idle_all();
        bus4.wr_en = 1; bus4.wr_addr = 2'd2; bus4.wr_data = 8'hA5;
        tick();
        checks++;
        if (static_o4[23:16] !== 8'hA5 || bus4.err_o !== 1'b0) begin
            errors++;
            $display("FAIL write_reg2 got %h err=%b exp a5 err=0", static_o4[23:16], bus4.err_o);
        end
        idle_all();
        bus4.rd_en = 1; bus4.rd_addr = 2'd2;
        tick();
        idle_all();
        checks++;
        if (bus4.rd_valid !== 1'b1 || bus4.rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_reg2 got vld=%b dat=%h exp 1 a5", bus4.rd_valid, bus4.rd_data);
        end
        tick();
        checks++;
        if (bus4.rd_valid !== 1'b0 || bus4.rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL rd_hold got vld=%b dat=%h exp 0 a5", bus4.rd_valid, bus4.rd_data);
        end
    endtask

    task automatic test_same_cycle();
        idle_all();
        bus4.wr_en = 1; bus4.wr_addr = 2'd1; bus4.wr_data = 8'h7E;
        bus4.rd_en = 1; bus4.rd_addr = 2'd1;
        tick();
        checks++;
        if (bus4.rd_data !== 8'h22 || static_o4[15:8] !== 8'h7E) begin
            errors++;
            $display("FAIL same_cycle_old got dat=%h reg1=%h exp 22 7e", bus4.rd_data, static_o4[15:8]);
        end
        bus4.wr_en = 0;
        tick();
        checks++;
        if (bus4.rd_valid !== 1'b1 || bus4.rd_data !== 8'h7E) begin
            errors++;
            $display("FAIL same_cycle_new got vld=%b dat=%h exp 1 7e", bus4.rd_valid, bus4.rd_data);
        end
    endtask

    task automatic test_back_to_back();
        idle_all();
        bus4.rd_en = 1;
        for (int i = 0; i < 5; i++) begin
            bus4.rd_addr = 2'(3 - (i % 4));
            tick();
            checks++;
            if (bus4.rd_valid !== 1'b1 || bus4.rd_data !== e_rd_data) begin
                errors++;
                $display("FAIL back_to_back %0d got vld=%b dat=%h exp 1 %h", i, bus4.rd_valid, bus4.rd_data, e_rd_data);
            end
        end
        idle_all();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            bus4.wr_en   = 1'($urandom_range(0, 1));
            bus4.wr_addr = 2'($urandom_range(0, 3));
            bus4.wr_data = 8'($urandom);
            bus4.rd_en   = 1'($urandom_range(0, 1));
            bus4.rd_addr = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (bus4.rd_valid !== e_rd_valid || bus4.rd_data !== e_rd_data || bus4.err_o !== e_err) begin
                errors++;
                $display("FAIL random_rd %0d got vld=%b dat=%h err=%b exp %b %h %b",
                         i, bus4.rd_valid, bus4.rd_data, bus4.err_o, e_rd_valid, e_rd_data, e_err);
            end
            checks++;
            if (static_o4 !== pack4() || locked4 !== 1'b0) begin
                errors++;
                $display("FAIL random_regs %0d got %h lock=%b exp %h lock=0", i, static_o4, locked4, pack4());
            end
        end
        idle_all();
    endtask

    task automatic test_range();
        idle_all();
        bus3.rd_en = 1; bus3.rd_addr = 2'd0;
        tick();
        bus3.rd_addr = 2'd3;
        tick();
        bus3.rd_en = 0;
        checks++;
        if (bus3.rd_valid !== 1'b1 || bus3.rd_data !== 8'h00 || bus3.err_o !== 1'b1) begin
            errors++;
            $display("FAIL range_read got vld=%b dat=%h err=%b exp 1 00 1", bus3.rd_valid, bus3.rd_data, bus3.err_o);
        end
        bus3.wr_en = 1; bus3.wr_addr = 2'd3; bus3.wr_data = 8'hFF;
        tick();
        checks++;
        if (bus3.err_o !== 1'b1 || static_o3 !== 24'hCCBBAA) begin
            errors++;
            $display("FAIL range_write got err=%b regs=%h exp 1 ccbbaa", bus3.err_o, static_o3);
        end
        bus3.wr_addr = 2'd2; bus3.wr_data = 8'h5A;
        tick();
        bus3.wr_en = 0;
        checks++;
        if (bus3.err_o !== 1'b0 || static_o3 !== 24'h5ABBAA) begin
            errors++;
            $display("FAIL range_valid_write got err=%b regs=%h exp 0 5abbaa", bus3.err_o, static_o3);
        end
    endtask

    task automatic test_lock();
        idle_all();
        lock4 = 1;
        bus4.wr_en = 1; bus4.wr_addr = 2'd0; bus4.wr_data = 8'hF0;
        tick();
        checks++;
        if (locked4 !== 1'b1 || static_o4[7:0] !== 8'hF0 || bus4.err_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_with_write got lock=%b reg0=%h err=%b exp 1 f0 0", locked4, static_o4[7:0], bus4.err_o);
        end
        lock4 = 0;
        bus4.wr_data = 8'h0F;
        tick();
        bus4.wr_en = 0;
        checks++;
        if (bus4.err_o !== 1'b1 || static_o4[7:0] !== 8'hF0 || static_o4 !== pack4()) begin
            errors++;
            $display("FAIL locked_write got err=%b regs=%h exp 1 %h", bus4.err_o, static_o4, pack4());
        end
        lock4 = 1;
        bus4.rd_en = 1; bus4.rd_addr = 2'd0;
        tick();
        idle_all();
        checks++;
        if (bus4.err_o !== 1'b0 || locked4 !== 1'b1 || bus4.rd_data !== 8'hF0) begin
            errors++;
            $display("FAIL locked_read got err=%b lock=%b dat=%h exp 0 1 f0", bus4.err_o, locked4, bus4.rd_data);
        end
    endtask

    task automatic test_reset_locked();
        logic [31:0] fresh;
        idle_all();
        reset_n = 1'b0;
        tick();
        checks++;
        if (locked4 !== 1'b0 || static_o4 !== 32'h0 || bus4.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL relock_reset got lock=%b regs=%h dat=%h exp 0 0 0", locked4, static_o4, bus4.rd_data);
        end
        tick();
        fresh   = $urandom;
        static4 = fresh;
        reset_n = 1'b1;
        tick();
        checks++;
        if (static_o4 !== fresh || static_o4 !== pack4()) begin
            errors++;
            $display("FAIL recapture got %h exp %h", static_o4, fresh);
        end
        bus4.wr_en = 1; bus4.wr_addr = 2'd3; bus4.wr_data = 8'h3C;
        tick();
        idle_all();
        checks++;
        if (bus4.err_o !== 1'b0 || static_o4[31:24] !== 8'h3C || locked4 !== 1'b0) begin
            errors++;
            $display("FAIL rewrite got err=%b reg3=%h lock=%b exp 0 3c 0", bus4.err_o, static_o4[31:24], locked4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_range();
        test_lock();
        test_reset_locked();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
